rc5_block_encrypt: RTL and testbench
====================================

Name: rc5_block_encrypt

Overview:
- RC5-W/R block encryptor that sits directly downstream of the key mixer.
- Once key mixing completes, it reads the expanded subkey table S[0..T-1] from the shared S memory and encrypts one 2W-bit plaintext block per start.
- It uses the same read-only address/data port style as the key mixer's S interface.
- It is strictly sequential: it processes one half-round per two clock cycles.

Parameters:
- W, 32, word width in bits; the plaintext/ciphertext block is 2W bits.
- T, 26, S-table size; number of rounds R = T/2-1 (12 for the default).
- T_LENGTH, $clog2(T), S address width.
- ROTVALUE, $clog2(W), number of rotate-amount bits taken from a word.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- iStart  in  1  start request; sampled on the rising edge.
- iKeyReady  in  1  S table valid; tied to the key mixer's oDone.
- iPlain  in  2W  plaintext; [W-1:0] = A, [2W-1:W] = B.
- oS_address  out  T_LENGTH  S memory read address.
- iS_sub_i  in  W  S memory read data; valid one cycle after the address.
- oCipher  out  2W  ciphertext; [W-1:0] = A, [2W-1:W] = B.
- oBusy  out  1  high while an encryption is in progress.
- oDone  out  1  ciphertext valid; held high until the next accepted start.

Behaviour:
- Reset (asynchronous, any time, including mid-operation):
  - state = IDLE.
  - oS_address = 0, oCipher = 0, oBusy = 0, oDone = 0.
  - Internal A, B and the half-round index k are cleared to 0.
  - An in-flight block is discarded.
- Start acceptance:
  - iStart is accepted only in IDLE or DONE, and only when iKeyReady = 1.
  - iStart while busy is ignored.
  - iStart with iKeyReady = 0 is ignored, and the state does not change.
- On the accepting edge:
  - A and B are loaded from iPlain; k = 0; oS_address = 0.
  - oBusy = 1, oDone = 0; state = WAIT_S.
- Memory model: synchronous read. The address is presented in WAIT_S and the data is valid on iS_sub_i during UPDATE.
- States:
  - IDLE: holds outputs. Goes to WAIT_S on an accepted start.
  - WAIT_S: goes to UPDATE unconditionally.
  - UPDATE: applies half-round k at the edge leaving UPDATE (see below).
    - If k = T-1: state = DONE, oCipher = {B_new, A_new}, oDone = 1, oBusy = 0.
    - Otherwise: k = k+1, oS_address = k+1, state = WAIT_S.
  - DONE: holds oCipher and oDone. Goes to WAIT_S on an accepted start; oCipher is held until completion of the new block.
  - Any unused encoding goes to IDLE.
- Half-round arithmetic (all sums modulo 2^W, no carry out):
  - k = 0: A = A + S[0].
  - k = 1: B = B + S[1].
  - k >= 2, k even: A = rotl(A ^ B, B[ROTVALUE-1:0]) + S[k].
  - k >= 2, k odd: B = rotl(B ^ A, A[ROTVALUE-1:0]) + S[k].
  - The odd step uses the A value updated in the previous half-round.
- Rotate amount 0 passes the data unchanged.
- Latency: oDone rises exactly 2T rising edges after the accepting edge (52 for T = 26).
- oS_address sequence: 0, 1, …, T-1, with each value held for 2 cycles.
- No write port; this block never writes S.
- iKeyReady dropping mid-operation is not monitored; the block completes using whatever S data it reads. The system guarantees S is stable while oBusy = 1.

Decomposition:
- Shared package holds:
  - state encodings IDLE / WAIT_S / UPDATE / DONE (2-bit);
  - W, T and derived R / T_LENGTH / ROTVALUE defaults.
- One sub-module: rc5_rotl — a combinational W-bit rotate-left by ROTVALUE bits, parameterised by W, with the same barrel structure as the key mixer's shifter.
- The FSM, A/B registers and the adder stay in the top module.

Test Plan:
- All-zero S table, iPlain = 0, start -> oDone after 52 cycles, oCipher = 0, oBusy low in DONE.
- S from mixing an all-zero 16-byte key (RC5-32/12/16), iPlain = 0 -> oCipher[31:0] = 0xEEDBA521, oCipher[63:32] = 0x6D8F4B15.
- Same S, second start from DONE with a new plaintext -> oDone drops on the accepting edge; the result matches the golden model 52 cycles later; oS_address retraces 0..25.
- iStart with iKeyReady = 0 -> stays in IDLE, oBusy = 0, oS_address = 0; iStart pulses during oBusy = 1 -> ignored, cycle count unchanged.
- Assert rst at cycle 20 of an encryption -> all outputs 0 immediately; a subsequent start yields the correct ciphertext.
- Random S tables and plaintexts (≥ 200 blocks) against a C reference model -> bit-exact oCipher; the rotate-by-0 and rotate-by-31 cases are explicitly hit.

Source files
------------

// File: rtl/rc5_block_encrypt_pkg.sv
// Shared definitions for the RC5 block encryptor: default geometry and FSM encoding.
// The geometry follows the key mixer's S table.
package rc5_block_encrypt_pkg;

  localparam int W_DEF        = 32;
  localparam int T_DEF        = 26;
  localparam int R_DEF        = T_DEF / 2 - 1;
  localparam int T_LENGTH_DEF = $clog2(T_DEF);
  localparam int ROTVALUE_DEF = $clog2(W_DEF);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT_S = 2'd1,
    UPDATE = 2'd2,
    DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/rc5_rotl.sv
// Combinational W-bit rotate-left, built as a log2(W)-stage barrel.
// Stage i rotates by 2^i when amount[i] is set.
module rc5_rotl
  import rc5_block_encrypt_pkg::*;
#(
  parameter int W        = W_DEF,
  parameter int ROTVALUE = $clog2(W)
) (
  input  logic [W-1:0]        data,
  input  logic [ROTVALUE-1:0] amount,
  output logic [W-1:0]        result
);

  logic [W-1:0] stage_s [ROTVALUE+1];

  assign stage_s[0] = data;

  for (genvar i = 0; i < ROTVALUE; i++) begin : g_stage
    localparam int SH = 1 << i;
    assign stage_s[i+1] = amount[i] ? {stage_s[i][W-1-SH:0], stage_s[i][W-1:W-SH]}
                                    : stage_s[i];
  end

  assign result = stage_s[ROTVALUE];

endmodule

// File: rtl/rc5_block_encrypt.sv
// RC5-W/R block encryptor reading the expanded S table over a synchronous read port.
// Each half-round takes two cycles: present the address (WAIT_S), then combine the data (UPDATE).
module rc5_block_encrypt
  import rc5_block_encrypt_pkg::*;
#(
  parameter int W        = W_DEF,
  parameter int T        = T_DEF,
  parameter int T_LENGTH = $clog2(T),
  parameter int ROTVALUE = $clog2(W)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                iStart,
  input  logic                iKeyReady,
  input  logic [2*W-1:0]      iPlain,
  output logic [T_LENGTH-1:0] oS_address,
  input  logic [W-1:0]        iS_sub_i,
  output logic [2*W-1:0]      oCipher,
  output logic                oBusy,
  output logic                oDone
);

  state_t              state_r;
  state_t              state_next_s;
  logic [W-1:0]        a_r;
  logic [W-1:0]        b_r;
  logic [W-1:0]        a_next_s;
  logic [W-1:0]        b_next_s;
  logic [T_LENGTH-1:0] k_r;
  logic [T_LENGTH-1:0] k_next_s;
  logic [T_LENGTH-1:0] addr_next_s;
  logic [2*W-1:0]      cipher_next_s;
  logic                busy_next_s;
  logic                done_next_s;

  logic                accept_s;
  logic                k_odd_s;
  logic                k_low_s;
  logic                k_last_s;
  logic [W-1:0]        rot_in_s;
  logic [ROTVALUE-1:0] rot_amt_s;
  logic [W-1:0]        rot_out_s;
  logic [W-1:0]        addend_s;
  logic [W-1:0]        sum_s;
  logic [W-1:0]        a_new_s;
  logic [W-1:0]        b_new_s;

  assign accept_s = iStart & iKeyReady & ((state_r == IDLE) | (state_r == DONE));
  assign k_odd_s  = k_r[0];
  assign k_low_s  = (k_r < T_LENGTH'(2));
  assign k_last_s = (k_r == T_LENGTH'(T - 1));

  // A^B and B^A are identical; only the rotate amount differs between even and odd steps.
  assign rot_in_s  = a_r ^ b_r;
  assign rot_amt_s = k_odd_s ? a_r[ROTVALUE-1:0] : b_r[ROTVALUE-1:0];

  rc5_rotl #(
    .W        (W),
    .ROTVALUE (ROTVALUE)
  ) u_rotl (
    .data   (rot_in_s),
    .amount (rot_amt_s),
    .result (rot_out_s)
  );

  // The first two half-rounds are plain whitening adds with no rotation.
  assign addend_s = k_low_s ? (k_odd_s ? b_r : a_r) : rot_out_s;
  assign sum_s    = addend_s + iS_sub_i;
  assign a_new_s  = k_odd_s ? a_r : sum_s;
  assign b_new_s  = k_odd_s ? sum_s : b_r;

  // Next-state and next-register computation for the encryption sequencer.
  always_comb begin
    state_next_s  = state_r;
    a_next_s      = a_r;
    b_next_s      = b_r;
    k_next_s      = k_r;
    addr_next_s   = oS_address;
    cipher_next_s = oCipher;
    busy_next_s   = oBusy;
    done_next_s   = oDone;
    case (state_r)
      IDLE, DONE: begin
        if (accept_s) begin
          state_next_s = WAIT_S;
          a_next_s     = iPlain[W-1:0];
          b_next_s     = iPlain[2*W-1:W];
          k_next_s     = {T_LENGTH{1'b0}};
          addr_next_s  = {T_LENGTH{1'b0}};
          busy_next_s  = 1'b1;
          done_next_s  = 1'b0;
        end else begin
          state_next_s = state_r;
        end
      end
      WAIT_S: begin
        state_next_s = UPDATE;
      end
      UPDATE: begin
        a_next_s = a_new_s;
        b_next_s = b_new_s;
        if (k_last_s) begin
          state_next_s  = DONE;
          cipher_next_s = {b_new_s, a_new_s};
          done_next_s   = 1'b1;
          busy_next_s   = 1'b0;
        end else begin
          state_next_s = WAIT_S;
          k_next_s     = k_r + T_LENGTH'(1);
          addr_next_s  = k_r + T_LENGTH'(1);
        end
      end
      default: begin
        state_next_s = IDLE;
        busy_next_s  = 1'b0;
        done_next_s  = 1'b0;
      end
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      a_r        <= {W{1'b0}};
      b_r        <= {W{1'b0}};
      k_r        <= {T_LENGTH{1'b0}};
      oS_address <= {T_LENGTH{1'b0}};
      oCipher    <= {(2*W){1'b0}};
      oBusy      <= 1'b0;
      oDone      <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      a_r        <= a_next_s;
      b_r        <= b_next_s;
      k_r        <= k_next_s;
      oS_address <= addr_next_s;
      oCipher    <= cipher_next_s;
      oBusy      <= busy_next_s;
      oDone      <= done_next_s;
    end
  end

endmodule

// File: tb/tb_rc5_block_encrypt.sv
// Self-checking bench for rc5_block_encrypt (RC5-32/12, T = 26).
// Uses a vector table, hand sequences and randomized blocks checked against a textbook RC5 model.
module tb_rc5_block_encrypt;

  localparam int W  = 32;
  localparam int T  = 26;
  localparam int TL = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          iStart;
  logic          iKeyReady;
  logic [63:0]   iPlain;
  logic [TL-1:0] oS_address;
  logic [31:0]   iS_sub_i;
  logic [63:0]   oCipher;
  logic          oBusy;
  logic          oDone;

  rc5_block_encrypt dut (
    .clk        (clk),
    .rst        (rst),
    .iStart     (iStart),
    .iKeyReady  (iKeyReady),
    .iPlain     (iPlain),
    .oS_address (oS_address),
    .iS_sub_i   (iS_sub_i),
    .oCipher    (oCipher),
    .oBusy      (oBusy),
    .oDone      (oDone)
  );

  always #5 clk = ~clk;

  logic [31:0] s_mem [T];

  always @(posedge clk) iS_sub_i <= s_mem[oS_address];

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
    int m;
    m = n % 32;
    if (m == 0) return x;
    return (x << m) | (x >> (32 - m));
  endfunction

  // Textbook RC5 encryption over the current S table.
  function automatic logic [63:0] model(input logic [63:0] p);
    logic [31:0] a;
    logic [31:0] b;
    a = p[31:0] + s_mem[0];
    b = p[63:32] + s_mem[1];
    for (int r = 1; r <= 12; r++) begin
      a = rotl(a ^ b, int'(b[4:0])) + s_mem[2*r];
      b = rotl(b ^ a, int'(a[4:0])) + s_mem[2*r+1];
    end
    return {b, a};
  endfunction

  // RC5-32/12/16 key schedule for an all-zero 16-byte key.
  function automatic void expand_zero_key();
    logic [31:0] l [4];
    logic [31:0] a;
    logic [31:0] b;
    int i;
    int j;
    s_mem[0] = 32'hB7E15163;
    for (int n = 1; n < T; n++) s_mem[n] = s_mem[n-1] + 32'h9E3779B9;
    for (int n = 0; n < 4; n++) l[n] = 32'h0;
    a = 32'h0; b = 32'h0; i = 0; j = 0;
    for (int n = 0; n < 3 * T; n++) begin
      a = rotl(s_mem[i] + a + b, 3);
      s_mem[i] = a;
      b = rotl(l[j] + a + b, int'((a + b) & 32'd31));
      l[j] = b;
      i = (i + 1) % T;
      j = (j + 1) % 4;
    end
  endfunction

  function automatic void zero_s();
    for (int n = 0; n < T; n++) s_mem[n] = 32'h0;
  endfunction

  function automatic void random_s();
    for (int n = 0; n < T; n++) s_mem[n] = $urandom;
  endfunction

  // Start one block and follow it to completion, checking timing, address trace and result.
  task automatic run_block(input logic [63:0] plain, input logic [63:0] exp,
                           input bit pulse, input string tag);
    logic [63:0] prev;
    int cyc;
    int addr_err;
    int hold_err;
    int busy_err;
    prev = oCipher;
    iKeyReady = 1'b1;
    iPlain = plain;
    iStart = 1'b1;
    @(posedge clk); #1;
    iStart = 1'b0;
    iPlain = ~plain;
    cyc = 0; addr_err = 0; hold_err = 0; busy_err = 0;
    while (!oDone && cyc < 200) begin
      if (oS_address !== TL'(cyc / 2)) addr_err++;
      if (oBusy !== 1'b1) busy_err++;
      if (oCipher !== prev) hold_err++;
      if (pulse) iStart = 1'($urandom_range(1, 0));
      @(posedge clk); #1;
      cyc++;
    end
    iStart = 1'b0;
    chk({tag, " latency"}, 64'(cyc), 64'd52);
    chk({tag, " cipher"}, oCipher, exp);
    chk({tag, " busy_in_done"}, 64'(oBusy), 64'd0);
    chk({tag, " addr_trace_errs"}, 64'(addr_err), 64'd0);
    chk({tag, " busy_errs"}, 64'(busy_err), 64'd0);
    chk({tag, " cipher_hold_errs"}, 64'(hold_err), 64'd0);
  endtask

  typedef struct {
    bit          zero_key_s;
    logic [63:0] plain;
    logic [63:0] expect_ct;
    bit          use_model;
    string       name;
  } vec_t;

  vec_t vecs [4];

  initial begin
    logic [63:0] exp;
    logic [63:0] last;
    logic [63:0] p;

    vecs[0] = '{1'b0, 64'h0, 64'h0, 1'b0, "zeroS_zeroP"};
    vecs[1] = '{1'b1, 64'h0, {32'h6D8F4B15, 32'hEEDBA521}, 1'b0, "zerokey_zeroP"};
    vecs[2] = '{1'b0, {32'h0000001F, 32'h0}, 64'h0, 1'b1, "zeroS_rot31"};
    vecs[3] = '{1'b1, 64'h0123456789ABCDEF, 64'h0, 1'b1, "zerokey_p1"};

    rst = 1'b1; iStart = 1'b0; iKeyReady = 1'b0; iPlain = 64'h0;
    zero_s();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset addr", 64'(oS_address), 64'd0);
    chk("reset cipher", oCipher, 64'h0);
    chk("reset busy", 64'(oBusy), 64'd0);
    chk("reset done", 64'(oDone), 64'd0);

    // Start with the key not ready: must stay idle.
    iKeyReady = 1'b0; iStart = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("nokey idle busy", 64'(oBusy), 64'd0);
    chk("nokey idle addr", 64'(oS_address), 64'd0);
    chk("nokey idle done", 64'(oDone), 64'd0);
    iStart = 1'b0;

    for (int v = 0; v < 4; v++) begin
      if (vecs[v].zero_key_s) expand_zero_key();
      else zero_s();
      exp = vecs[v].use_model ? model(vecs[v].plain) : vecs[v].expect_ct;
      run_block(vecs[v].plain, exp, 1'b0, vecs[v].name);
    end

    // Second start from DONE with stray starts while busy.
    p = {$urandom, $urandom};
    run_block(p, model(p), 1'b1, "redo_pulsed");
    last = oCipher;

    // Start in DONE with the key not ready: result and state held.
    iKeyReady = 1'b0; iStart = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("nokey done done", 64'(oDone), 64'd1);
    chk("nokey done busy", 64'(oBusy), 64'd0);
    chk("nokey done cipher", oCipher, last);
    iStart = 1'b0;

    // Asynchronous reset in the middle of a block.
    iKeyReady = 1'b1; iPlain = {$urandom, $urandom}; iStart = 1'b1;
    @(posedge clk); #1;
    iStart = 1'b0;
    repeat (19) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst addr", 64'(oS_address), 64'd0);
    chk("midrst cipher", oCipher, 64'h0);
    chk("midrst busy", 64'(oBusy), 64'd0);
    chk("midrst done", 64'(oDone), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    p = {$urandom, $urandom};
    run_block(p, model(p), 1'b0, "after_rst");

    // Randomized S tables and plaintexts.
    for (int n = 0; n < 200; n++) begin
      if (n % 8 == 0) random_s();
      p = {$urandom, $urandom};
      run_block(p, model(p), (n % 5) == 0, "random");
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
